// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a registered-read program ROM.
// Issues sequential fetches, absorbs ROM responses in a 2-entry queue and hands them to decode.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [1:0]         count;
    logic [INSTR_W-1:0] data0, data1;
    logic [ADDR_W-1:0]  addr0, addr1;

    logic       pop;
    logic       push;
    logic [2:0] occ_after;

    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~redirect;
    assign instr_valid = (count != 2'd0);
    assign instr       = data0;
    assign instr_pc    = addr0;
    assign rom_addr    = pc;

    // Only issue when the response is guaranteed a free queue slot next cycle.
    assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign rom_en    = rst_n & ~halt & ~redirect & (occ_after < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                pc          <= pc + ADDR_W'(1);
                inflight_pc <= pc;
            end
        end
    end

    // Entry 0 is always the head, so instr/instr_pc come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            data0 <= '0;
            addr0 <= '0;
            data1 <= '0;
            addr1 <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= rom_data;
                        addr0 <= inflight_pc;
                    end else begin
                        data1 <= rom_data;
                        addr1 <= inflight_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    addr0 <= addr1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data0 <= rom_data;
                        addr0 <= inflight_pc;
                    end else begin
                        data0 <= data1;
                        addr0 <= addr1;
                        data1 <= rom_data;
                        addr1 <= inflight_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the ROM model returns 0xA000+addr one cycle after rom_en.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] nxt;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= 16'hA000 + {8'h00, rom_addr};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic rdy, input logic rdir, input logic [7:0] rpc);
        halt        = h;
        instr_ready = rdy;
        redirect    = rdir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expectHead(input string tag, input logic [7:0] pc);
        logic [15:0] word;
        word = 16'hA000 + {8'h00, pc};
        checkOutput({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        checkOutput({tag, ".pc"}, {24'd0, instr_pc}, {24'd0, pc});
        checkOutput({tag, ".instr"}, {16'd0, instr}, {16'd0, word});
    endtask

    // Expects consecutive PCs starting at nxt, one per cycle, with decode always ready.
    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            expectHead(tag, nxt);
            nxt = nxt + 8'd1;
            tick();
        end
    endtask

    task automatic doRedirect(input string tag, input logic [7:0] target);
        applyStimulus(1'b0, 1'b0, 1'b1, target);
        checkOutput({tag, ".rom_en_t"}, {31'd0, rom_en}, 32'd0);
        tick();
        checkOutput({tag, ".flush"}, {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput({tag, ".rom_en_t1"}, {31'd0, rom_en}, 32'd1);
        checkOutput({tag, ".rom_addr_t1"}, {24'd0, rom_addr}, {24'd0, target});
        tick();
        checkOutput({tag, ".valid_t1"}, {31'd0, instr_valid}, 32'd0);
        tick();
        nxt = target;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("reset.valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset.instr", {16'd0, instr}, 32'd0);
        checkOutput("reset.pc", {24'd0, instr_pc}, 32'd0);
        checkOutput("reset.rom_en", {31'd0, rom_en}, 32'd0);

        rst_n = 1'b1;
        #1;
        checkOutput("start.rom_en", {31'd0, rom_en}, 32'd1);
        checkOutput("start.rom_addr", {24'd0, rom_addr}, 32'd0);
        tick();
        checkOutput("start.lat1", {31'd0, instr_valid}, 32'd0);
        tick();
        nxt = 8'h00;
        stream("stream", 3);

        // Backpressure: head must freeze and no fetch may issue while the queue is full.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("bp.rom_en", {31'd0, rom_en}, 32'd0);
            tick();
            expectHead("bp.hold", nxt);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        stream("bp.resume", 4);

        doRedirect("redir", 8'h40);
        stream("redir.seq", 3);

        doRedirect("wrap", 8'hFE);
        stream("wrap.seq", 4);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
        checkOutput("b2b.rom_en", {31'd0, rom_en}, 32'd0);
        tick();
        checkOutput("b2b.flush", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("b2b.rom_addr", {24'd0, rom_addr}, 32'h20);
        tick();
        tick();
        nxt = 8'h20;
        stream("b2b.seq", 2);

        // Halt: the head pops, the in-flight entry still lands, then the queue runs dry.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
            checkOutput("halt.rom_en", {31'd0, rom_en}, 32'd0);
            tick();
            if (i == 0) expectHead("halt.drain", nxt + 8'd1);
            else checkOutput("halt.empty", {31'd0, instr_valid}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("halt.resume_en", {31'd0, rom_en}, 32'd1);
        checkOutput("halt.resume_addr", {24'd0, rom_addr}, {24'd0, nxt + 8'd2});
        tick();
        checkOutput("halt.resume_lat", {31'd0, instr_valid}, 32'd0);
        tick();
        nxt = nxt + 8'd2;
        stream("halt.seq", 2);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h80);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("hredir.rom_en", {31'd0, rom_en}, 32'd0);
        tick();
        checkOutput("hredir.flush", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("hredir.rom_addr", {24'd0, rom_addr}, 32'h80);
        tick();
        tick();
        nxt = 8'h80;
        stream("hredir.seq", 2);

        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("areset.rom_en", {31'd0, rom_en}, 32'd0);
        checkOutput("areset.pc", {24'd0, instr_pc}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("areset.rom_addr", {24'd0, rom_addr}, 32'd0);
        tick();
        checkOutput("areset.lat1", {31'd0, instr_valid}, 32'd0);
        tick();
        nxt = 8'h00;
        stream("areset.seq", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
